// File: rtl/sram_1rw1r_bypass_ram.sv
`default_nettype none
// ============================================================================
// Module   : sram_1rw1r_bypass_ram
// Purpose  : Parametrised one-read/write plus one-read-only synchronous RAM.
//            It is the RTL/FPGA stand-in for the OpenRAM macros. It has byte
//            write masks, 1- or 2-cycle read latency, read-valid strobes,
//            defined write/read collision behaviour with optional
//            write-through bypass, and an optional post-reset zeroing sweep.
// Ports    : clk        - single clock for both ports
//            rst_l      - asynchronous active-low reset
//            init_busy  - high while the zeroing sweep runs (requests dropped)
//            csb0/web0  - port 0 chip select / write enable (active low)
//            wmask0     - port 0 byte write mask, bit i -> din0[8i+7:8i]
//            addr0/din0 - port 0 address / write data
//            dout0      - port 0 read data, dout0_vld pulses on new data
//            csb1/addr1 - port 1 chip select (active low) / address
//            dout1      - port 1 read data, dout1_vld pulses on new data
//            collision  - pulses with dout1_vld when that read hit a
//                         same-edge port 0 write to the same address
// Notes    : DATA_WIDTH must equal NUM_WMASKS*8. READ_LATENCY is 1 or 2.
// Revision : 1.0 - initial release
// ============================================================================
module sram_1rw1r_bypass_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WMASKS   = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  rst_l,
  output logic                  init_busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_vld,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  collision
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  // Sweep counter is one bit wider than the address so completion is visible.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_BUSY  = (INIT_ZERO != 0);

  // Replace the masked byte lanes of old_w with those of new_w.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Storage. Deliberately not reset: with INIT_ZERO=0 contents survive reset.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // --------------------------------------------------------------------------
  // Control FSM and sweep counter
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                init_busy_q, init_busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      // The last zero write and the busy release share the same edge.
      if (cnt_q == CNT_LAST) begin
        state_d     = ST_RUN;
        init_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      init_busy_q <= RESET_BUSY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign init_busy = init_busy_q;

  // --------------------------------------------------------------------------
  // Request decode, write port mux and first read stage
  // --------------------------------------------------------------------------
  logic                  run;
  logic                  wr0_req, rd0_req, rd1_req, coll;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_WMASKS-1:0] mem_wmask;
  logic [DATA_WIDTH-1:0] rd1_word;

  logic                  rd0_vld_q, rd0_vld_d;
  logic [DATA_WIDTH-1:0] rd0_data_q, rd0_data_d;
  logic                  rd1_vld_q, rd1_vld_d;
  logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic                  coll_q, coll_d;

  always_comb begin
    run     = (state_q == ST_RUN);
    wr0_req = run && !csb0 && !web0;
    rd0_req = run && !csb0 && web0;
    rd1_req = run && !csb1;
    // A write with wmask0=0 is still a write transaction, so it still flags.
    coll    = rd1_req && wr0_req && (addr0 == addr1);

    mem_we    = wr0_req;
    mem_waddr = addr0;
    mem_wdata = din0;
    mem_wmask = wmask0;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[ADDR_WIDTH-1:0];
      mem_wdata = '0;
      mem_wmask = '1;
    end

    // Array read returns the pre-write word; bypass patches in the new lanes.
    rd1_word = mem[addr1];
    if ((BYPASS != 0) && coll) rd1_word = merge_bytes(rd1_word, din0, wmask0);

    rd0_vld_d  = rd0_req;
    rd0_data_d = rd0_req ? mem[addr0] : rd0_data_q;
    rd1_vld_d  = rd1_req;
    rd1_data_d = rd1_req ? rd1_word : rd1_data_q;
    coll_d     = coll;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (mem_wmask[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd0_vld_q  <= 1'b0;
      rd0_data_q <= '0;
      rd1_vld_q  <= 1'b0;
      rd1_data_q <= '0;
      coll_q     <= 1'b0;
    end else begin
      rd0_vld_q  <= rd0_vld_d;
      rd0_data_q <= rd0_data_d;
      rd1_vld_q  <= rd1_vld_d;
      rd1_data_q <= rd1_data_d;
      coll_q     <= coll_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: direct for latency 1, one extra register for latency 2
  // --------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  out0_vld_q, out0_vld_d;
      logic [DATA_WIDTH-1:0] out0_data_q, out0_data_d;
      logic                  out1_vld_q, out1_vld_d;
      logic [DATA_WIDTH-1:0] out1_data_q, out1_data_d;
      logic                  out_coll_q, out_coll_d;

      always_comb begin
        out0_vld_d  = rd0_vld_q;
        out0_data_d = rd0_vld_q ? rd0_data_q : out0_data_q;
        out1_vld_d  = rd1_vld_q;
        out1_data_d = rd1_vld_q ? rd1_data_q : out1_data_q;
        out_coll_d  = coll_q;
      end

      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          out0_vld_q  <= 1'b0;
          out0_data_q <= '0;
          out1_vld_q  <= 1'b0;
          out1_data_q <= '0;
          out_coll_q  <= 1'b0;
        end else begin
          out0_vld_q  <= out0_vld_d;
          out0_data_q <= out0_data_d;
          out1_vld_q  <= out1_vld_d;
          out1_data_q <= out1_data_d;
          out_coll_q  <= out_coll_d;
        end
      end

      assign dout0     = out0_data_q;
      assign dout0_vld = out0_vld_q;
      assign dout1     = out1_data_q;
      assign dout1_vld = out1_vld_q;
      assign collision = out_coll_q;
    end else begin : g_lat1
      assign dout0     = rd0_data_q;
      assign dout0_vld = rd0_vld_q;
      assign dout1     = rd1_data_q;
      assign dout1_vld = rd1_vld_q;
      assign collision = coll_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_bypass_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1rw1r_bypass_ram
// Purpose  : Directed self-checking bench. Three instances share stimulus:
//            a = latency 1, bypass on,  zeroing sweep on
//            b = latency 2, bypass off, zeroing sweep on
//            c = latency 1, bypass on,  no zeroing sweep
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1rw1r_bypass_ram;

  logic        clk;
  logic        rst_l;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic        a_busy, a_v0, a_v1, a_coll;
  logic [31:0] a_d0, a_d1;
  logic        b_busy, b_v0, b_v1, b_coll;
  logic [31:0] b_d0, b_d1;
  logic        c_busy, c_v0, c_v1, c_coll;
  logic [31:0] c_d0, c_d1;

  int n_tests = 0;
  int n_fail  = 0;

  sram_1rw1r_bypass_ram #(.READ_LATENCY(1), .BYPASS(1), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst_l(rst_l), .init_busy(a_busy),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(a_d0), .dout0_vld(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_d1), .dout1_vld(a_v1),
    .collision(a_coll)
  );

  sram_1rw1r_bypass_ram #(.READ_LATENCY(2), .BYPASS(0), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst_l(rst_l), .init_busy(b_busy),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(b_d0), .dout0_vld(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_d1), .dout1_vld(b_v1),
    .collision(b_coll)
  );

  sram_1rw1r_bypass_ram #(.READ_LATENCY(1), .BYPASS(1), .INIT_ZERO(0)) dut_c (
    .clk(clk), .rst_l(rst_l), .init_busy(c_busy),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(c_d0), .dout0_vld(c_v0),
    .csb1(csb1), .addr1(addr1), .dout1(c_d1), .dout1_vld(c_v1),
    .collision(c_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0   = 1'b1;
    web0   = 1'b1;
    csb1   = 1'b1;
    wmask0 = 4'b0000;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
    step();
    idle();
  endtask

  // Step until a_busy falls (bounded). busy_cycles counts the cycle before
  // the first edge plus every sampled busy cycle; vld_seen counts any
  // valid pulse from the sweeping instances while busy or on the final edge.
  task automatic wait_init(output int busy_cycles, output int vld_seen, output logic b_busy_end);
    busy_cycles = 1;
    vld_seen    = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (a_v0 || a_v1 || b_v0 || b_v1 || a_coll || b_coll) vld_seen++;
      if (a_busy !== 1'b1) break;
      busy_cycles++;
    end
    b_busy_end = b_busy;
  endtask

  task automatic test_reset();
    int   bc, vs;
    logic bb;
    rst_l = 1'b0;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h05; din0 = '0; wmask0 = '0;
    csb1 = 1'b0; addr1 = 8'h05;
    #12;
    n_tests++; if (a_d0 !== 32'h0 || a_d1 !== 32'h0) begin n_fail++; $display("FAIL reset_dout_a: got %h/%h want 0/0", a_d0, a_d1); end
    n_tests++; if ({a_v0, a_v1, a_coll, b_v0, b_v1, b_coll} !== 6'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 000000", {a_v0, a_v1, a_coll, b_v0, b_v1, b_coll}); end
    n_tests++; if ({a_busy, b_busy, c_busy} !== 3'b110) begin n_fail++; $display("FAIL reset_busy: got %b want 110", {a_busy, b_busy, c_busy}); end
    @(posedge clk); #1;
    rst_l = 1'b1;
    step();
    n_tests++; if (c_v0 !== 1'b1 || c_busy !== 1'b0) begin n_fail++; $display("FAIL noinit_first_read: vld=%b busy=%b want 1/0", c_v0, c_busy); end
    wait_init(bc, vs, bb);
    // The first edge was consumed above, so one more busy cycle is owed.
    bc = bc + 1;
    n_tests++; if (bc !== 256) begin n_fail++; $display("FAIL init_busy_len: got %0d want 256", bc); end
    n_tests++; if (vs !== 0) begin n_fail++; $display("FAIL init_vld_dropped: got %0d pulses want 0", vs); end
    n_tests++; if (bb !== 1'b0) begin n_fail++; $display("FAIL init_busy_b: got %b want 0", bb); end
    step();
    n_tests++; if (a_v0 !== 1'b1 || a_d0 !== 32'h0 || a_v1 !== 1'b1 || a_d1 !== 32'h0) begin n_fail++; $display("FAIL first_read_a: vld=%b%b d0=%h d1=%h want 11 0 0", a_v0, a_v1, a_d0, a_d1); end
    n_tests++; if (b_v0 !== 1'b0) begin n_fail++; $display("FAIL first_read_b_early: vld=%b want 0", b_v0); end
    idle();
    step();
    n_tests++; if (b_v0 !== 1'b1 || b_d0 !== 32'h0 || a_v0 !== 1'b0) begin n_fail++; $display("FAIL first_read_b: bvld=%b bd0=%h avld=%b want 1 0 0", b_v0, b_d0, a_v0); end
  endtask

  task automatic test_masked_write();
    wr(8'h10, 32'hDEADBEEF, 4'b1111);
    n_tests++; if (a_v0 !== 1'b0) begin n_fail++; $display("FAIL write_no_vld: got %b want 0", a_v0); end
    wr(8'h10, 32'h11223344, 4'b0101);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
    step();
    idle();
    n_tests++; if (a_d0 !== 32'hDE22BE44 || a_v0 !== 1'b1) begin n_fail++; $display("FAIL mask_read_a: got %h vld=%b want DE22BE44 1", a_d0, a_v0); end
    n_tests++; if (b_v0 !== 1'b0) begin n_fail++; $display("FAIL mask_read_b_early: vld=%b want 0", b_v0); end
    step();
    n_tests++; if (a_v0 !== 1'b0 || a_d0 !== 32'hDE22BE44) begin n_fail++; $display("FAIL mask_hold_a: got %h vld=%b want DE22BE44 0", a_d0, a_v0); end
    n_tests++; if (b_d0 !== 32'hDE22BE44 || b_v0 !== 1'b1) begin n_fail++; $display("FAIL mask_read_b: got %h vld=%b want DE22BE44 1", b_d0, b_v0); end
    step();
    n_tests++; if (b_v0 !== 1'b0) begin n_fail++; $display("FAIL mask_pulse_b: vld=%b want 0", b_v0); end
  endtask

  task automatic test_collision();
    wr(8'h20, 32'hAAAAAAAA, 4'b1111);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'h55555555; wmask0 = 4'b0011;
    csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    n_tests++; if (a_d1 !== 32'hAAAA5555 || a_v1 !== 1'b1 || a_coll !== 1'b1) begin n_fail++; $display("FAIL coll_bypass: got %h vld=%b coll=%b want AAAA5555 1 1", a_d1, a_v1, a_coll); end
    n_tests++; if (b_coll !== 1'b0) begin n_fail++; $display("FAIL coll_b_early: coll=%b want 0", b_coll); end
    step();
    n_tests++; if (a_coll !== 1'b0 || a_v1 !== 1'b0) begin n_fail++; $display("FAIL coll_pulse_a: coll=%b vld=%b want 0 0", a_coll, a_v1); end
    n_tests++; if (b_d1 !== 32'hAAAAAAAA || b_v1 !== 1'b1 || b_coll !== 1'b1) begin n_fail++; $display("FAIL coll_nobypass: got %h vld=%b coll=%b want AAAAAAAA 1 1", b_d1, b_v1, b_coll); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h20; csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    n_tests++; if (a_d1 !== 32'hAAAA5555 || a_coll !== 1'b0 || a_d0 !== 32'hAAAA5555) begin n_fail++; $display("FAIL read_read_a: d1=%h d0=%h coll=%b want AAAA5555 AAAA5555 0", a_d1, a_d0, a_coll); end
    step();
    n_tests++; if (b_d1 !== 32'hAAAA5555 || b_coll !== 1'b0 || b_v1 !== 1'b1) begin n_fail++; $display("FAIL read_read_b: d1=%h vld=%b coll=%b want AAAA5555 1 0", b_d1, b_v1, b_coll); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    logic        exp_av, exp_bv;
    for (int i = 0; i < 8; i++) wr(8'(i), 32'(i) * 32'h01010101, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      csb1  = (i < 8) ? 1'b0 : 1'b1;
      addr1 = 8'(i);
      step();
      idle();
      exp_av = (i < 8);
      exp_bv = (i >= 1 && i <= 8);
      n_tests++; if (a_v1 !== exp_av) begin n_fail++; $display("FAIL stream_vld_a[%0d]: got %b want %b", i, a_v1, exp_av); end
      if (exp_av) begin
        exp_d = 32'(i) * 32'h01010101;
        n_tests++; if (a_d1 !== exp_d) begin n_fail++; $display("FAIL stream_data_a[%0d]: got %h want %h", i, a_d1, exp_d); end
      end
      n_tests++; if (b_v1 !== exp_bv) begin n_fail++; $display("FAIL stream_vld_b[%0d]: got %b want %b", i, b_v1, exp_bv); end
      if (exp_bv) begin
        exp_d = 32'(i - 1) * 32'h01010101;
        n_tests++; if (b_d1 !== exp_d) begin n_fail++; $display("FAIL stream_data_b[%0d]: got %h want %h", i, b_d1, exp_d); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int   bc, vs;
    logic bb;
    wr(8'h30, 32'hDEADBEEF, 4'b1111);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h30; csb1 = 1'b0; addr1 = 8'h30;
    step();
    n_tests++; if (a_d0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_read: got %h want DEADBEEF", a_d0); end
    #2;
    rst_l = 1'b0;
    #1;
    n_tests++; if (a_d0 !== 32'h0 || b_d0 !== 32'h0 || a_d1 !== 32'h0 || b_d1 !== 32'h0) begin n_fail++; $display("FAIL async_reset_data: a=%h/%h b=%h/%h want 0", a_d0, a_d1, b_d0, b_d1); end
    n_tests++; if ({a_v0, b_v0, a_busy, b_busy, c_busy} !== 5'b00110) begin n_fail++; $display("FAIL async_reset_ctl: got %b want 00110", {a_v0, b_v0, a_busy, b_busy, c_busy}); end
    step();
    n_tests++; if (b_v0 !== 1'b0) begin n_fail++; $display("FAIL inflight_dropped: vld=%b want 0", b_v0); end
    rst_l = 1'b1;
    wait_init(bc, vs, bb);
    n_tests++; if (bc !== 256) begin n_fail++; $display("FAIL reinit_busy_len: got %0d want 256", bc); end
    n_tests++; if (vs !== 0) begin n_fail++; $display("FAIL reinit_vld: got %0d pulses want 0", vs); end
    step();
    n_tests++; if (a_d0 !== 32'h0 || a_v0 !== 1'b1 || a_d1 !== 32'h0) begin n_fail++; $display("FAIL swept_read_a: d0=%h vld=%b d1=%h want 0 1 0", a_d0, a_v0, a_d1); end
    n_tests++; if (c_d0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL retained_c: got %h want DEADBEEF", c_d0); end
    idle();
    step();
    n_tests++; if (b_d0 !== 32'h0 || b_v0 !== 1'b1) begin n_fail++; $display("FAIL swept_read_b: got %h vld=%b want 0 1", b_d0, b_v0); end
  endtask

  task automatic test_no_init();
    wr(8'hFF, 32'hCAFEF00D, 4'b1111);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'hFF; csb1 = 1'b0; addr1 = 8'hFF;
    step();
    idle();
    n_tests++; if (c_d0 !== 32'hCAFEF00D || c_v0 !== 1'b1) begin n_fail++; $display("FAIL wr_then_rd_p0: got %h vld=%b want CAFEF00D 1", c_d0, c_v0); end
    n_tests++; if (c_d1 !== 32'hCAFEF00D || c_v1 !== 1'b1 || c_coll !== 1'b0) begin n_fail++; $display("FAIL wr_then_rd_p1: got %h vld=%b coll=%b want CAFEF00D 1 0", c_d1, c_v1, c_coll); end
    n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL noinit_busy: got %b want 0", c_busy); end
  endtask

  initial begin
    idle();
    addr0 = '0; addr1 = '0; din0 = '0;
    test_reset();
    test_masked_write();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    test_no_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
